// File: rtl/lcd_status_scheduler.sv
// Drives the 16x2 status LCD byte-writer: line 1 shows the highest-priority CPU
// status message, line 2 shows the DATA snapshot as "0x" plus 8 hex digits.
module lcd_status_scheduler #(
    parameter int unsigned REFRESH_CYCLES = 5000000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        isHalt,
    input  logic        isInsert,
    input  logic        isBios,
    input  logic        isTransf,
    input  logic [31:0] iDATA,
    output logic        oWR_REQ,
    output logic        oWR_RS,
    output logic [7:0]  oWR_BYTE,
    input  logic        iWR_ACK,
    output logic        oBUSY,
    output logic [2:0]  oMSG_ID
);

    localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
    localparam int unsigned IDX_W = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(33);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

    localparam logic [2:0] MSG_RUN    = 3'd0;
    localparam logic [2:0] MSG_TRANSF = 3'd1;
    localparam logic [2:0] MSG_BIOS   = 3'd2;
    localparam logic [2:0] MSG_INSERT = 3'd3;
    localparam logic [2:0] MSG_HALT   = 3'd4;

    typedef enum logic [1:0] {IDLE, START, ISSUE, NEXT} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pending, pending_n;
    logic [31:0]      snap, snap_n;
    logic [2:0]       msg_n;
    logic             req_n, rs_n, busy_n;
    logic [7:0]       byte_n;
    logic [2:0]       sel_msg_c;

    // Fixed priority: HALT > INSERT > BIOS > TRANSF > RUN
    always_comb begin
        if (isHalt)        sel_msg_c = MSG_HALT;
        else if (isInsert) sel_msg_c = MSG_INSERT;
        else if (isBios)   sel_msg_c = MSG_BIOS;
        else if (isTransf) sel_msg_c = MSG_TRANSF;
        else               sel_msg_c = MSG_RUN;
    end

    // {rs, byte} for one position of the 34-byte screen sequence
    function automatic logic [8:0] seq_byte(input logic [IDX_W-1:0] i,
                                            input logic [2:0] msg,
                                            input logic [31:0] data);
        logic [127:0] text;
        logic [127:0] text_sh;
        logic [31:0]  data_sh;
        logic [3:0]   pos;
        logic [2:0]   dig;
        logic [3:0]   nib;
        logic [8:0]   res;
        case (msg)
            MSG_HALT:   text = {"HALT", {12{8'h20}}};
            MSG_INSERT: text = {"INSERT DATA", {5{8'h20}}};
            MSG_BIOS:   text = {"BIOS", {12{8'h20}}};
            MSG_TRANSF: text = {"TRANSFER", {8{8'h20}}};
            default:    text = {"RUNNING", {9{8'h20}}};
        endcase
        pos     = 4'(i - IDX_W'(1));
        text_sh = text << {pos, 3'b000};
        dig     = 3'(i - IDX_W'(20));
        data_sh = data << {dig, 2'b00};
        nib     = data_sh[31:28];
        res     = {1'b1, 8'h20};
        if (i == IDX_W'(0))        res = {1'b0, 8'h80};
        else if (i <= IDX_W'(16))  res = {1'b1, text_sh[127:120]};
        else if (i == IDX_W'(17))  res = {1'b0, 8'hC0};
        else if (i == IDX_W'(18))  res = {1'b1, 8'h30};
        else if (i == IDX_W'(19))  res = {1'b1, 8'h78};
        else if (i <= IDX_W'(27))  res = (nib < 4'd10) ? {1'b1, 8'h30 + {4'h0, nib}}
                                                       : {1'b1, 8'h37 + {4'h0, nib}};
        return res;
    endfunction

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            pending  <= 1'b1;
            snap     <= '0;
            oMSG_ID  <= MSG_RUN;
            oWR_REQ  <= 1'b0;
            oWR_RS   <= 1'b0;
            oWR_BYTE <= 8'h00;
            oBUSY    <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            cnt      <= cnt_n;
            pending  <= pending_n;
            snap     <= snap_n;
            oMSG_ID  <= msg_n;
            oWR_REQ  <= req_n;
            oWR_RS   <= rs_n;
            oWR_BYTE <= byte_n;
            oBUSY    <= busy_n;
        end
    end

    // Next state; REQ/RS/BYTE are computed for the cycle they will be visible in
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        cnt_n     = '0;
        pending_n = pending | (sel_msg_c != oMSG_ID);
        snap_n    = snap;
        msg_n     = oMSG_ID;
        busy_n    = oBUSY;
        req_n     = 1'b0;
        rs_n      = oWR_RS;
        byte_n    = oWR_BYTE;
        case (state)
            IDLE: begin
                if (pending || cnt == CNT_LAST) state_n = START;
                else                            cnt_n   = cnt + CNT_W'(1);
            end
            START: begin
                msg_n          = sel_msg_c;
                snap_n         = iDATA;
                pending_n      = 1'b0;
                idx_n          = '0;
                busy_n         = 1'b1;
                req_n          = 1'b1;
                {rs_n, byte_n} = seq_byte(IDX_W'(0), sel_msg_c, iDATA);
                state_n        = ISSUE;
            end
            ISSUE: begin
                req_n = 1'b1;
                if (iWR_ACK) begin
                    req_n   = 1'b0;
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (idx == LAST_IDX) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else begin
                    idx_n          = idx + IDX_W'(1);
                    req_n          = 1'b1;
                    {rs_n, byte_n} = seq_byte(idx_n, oMSG_ID, snap);
                    state_n        = ISSUE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_status_scheduler.sv
// Scoreboard bench for lcd_status_scheduler: expected screens are built from
// text strings at each update start and checked byte by byte as they are acked.
module tb_lcd_status_scheduler;

    localparam int unsigned REFRESH = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt = 1'b0, insert = 1'b0, bios = 1'b0, transf = 1'b0;
    logic [31:0] data = 32'hDEADBEEF;
    logic        ack = 1'b0;
    logic        req, rs, busy;
    logic [7:0]  wbyte;
    logic [2:0]  msg_id;

    always #5 clk = ~clk;

    lcd_status_scheduler #(.REFRESH_CYCLES(REFRESH)) dut (
        .iCLK(clk), .iRST(rst),
        .isHalt(halt), .isInsert(insert), .isBios(bios), .isTransf(transf),
        .iDATA(data),
        .oWR_REQ(req), .oWR_RS(rs), .oWR_BYTE(wbyte), .iWR_ACK(ack),
        .oBUSY(busy), .oMSG_ID(msg_id)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    function automatic int model_sel(input logic h, input logic i, input logic b, input logic t);
        if (h) return 4;
        if (i) return 3;
        if (b) return 2;
        if (t) return 1;
        return 0;
    endfunction

    logic [8:0] exp_q[$];

    // Whole screen as text, then serialised as (rs, byte) pairs
    function automatic void push_screen(input int m, input logic [31:0] d);
        string l1, l2;
        string hexs = "0123456789ABCDEF";
        case (m)
            4:       l1 = "HALT";
            3:       l1 = "INSERT DATA";
            2:       l1 = "BIOS";
            1:       l1 = "TRANSFER";
            default: l1 = "RUNNING";
        endcase
        l2 = "0x";
        for (int k = 0; k < 8; k++) begin
            int nib;
            nib = int'(d[31-4*k -: 4]);
            l2 = {l2, hexs.substr(nib, nib)};
        end
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, (i < l1.len()) ? l1[i] : 8'h20});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, (i < l2.len()) ? l2[i] : 8'h20});
    endfunction

    // Reference-model state
    int          shown = 0;
    bit          changed = 1'b1;
    bit          tracking = 1'b1;
    int          idle_n = -1;
    int          pend_at = -1;
    int          last_sel = 0;
    logic [31:0] last_data = '0;
    bit          prev_busy = 1'b0;
    int          byte_idx = 0;
    int          updates_done = 0;

    // Inputs as the DUT sees them at each edge; any difference from the shown message marks a change
    always @(posedge clk) begin
        if (!rst) begin
            last_sel  = model_sel(halt, insert, bios, transf);
            last_data = data;
            if (last_sel != shown) changed = 1'b1;
        end
    end

    // Monitor: reset values, update start timing, and byte-by-byte scoreboard
    always @(negedge clk) begin
        if (rst) begin
            check("reset_req", {31'b0, req}, 0);
            check("reset_busy", {31'b0, busy}, 0);
            check("reset_msg", {29'b0, msg_id}, 0);
            check("reset_byte", {23'b0, rs, wbyte}, 0);
            exp_q.delete();
            shown = 0; changed = 1'b1; tracking = 1'b1;
            idle_n = -1; pend_at = -1; prev_busy = 1'b0; byte_idx = 0;
        end else begin
            if (tracking) idle_n++;
            if (busy && !prev_busy) begin
                int want_gap;
                want_gap = (pend_at >= 0 && pend_at < int'(REFRESH) - 1) ? pend_at + 2
                                                                          : int'(REFRESH) + 1;
                check("start_gap", 32'(idle_n), 32'(want_gap));
                tracking = 1'b0;
                shown    = last_sel;
                changed  = 1'b0;
                check("msg_id_at_start", {29'b0, msg_id}, 32'(shown));
                push_screen(shown, last_data);
                byte_idx = 0;
            end else if (!busy && prev_busy) begin
                check("queue_drained", 32'(exp_q.size()), 0);
                updates_done++;
                tracking = 1'b1; idle_n = 0; pend_at = -1;
            end
            if (tracking && pend_at < 0 && changed) pend_at = idle_n;
            if (req && ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL byte_unexpected: got rs=%0d byte=%02h, want none", rs, wbyte);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({rs, wbyte} !== e) begin
                        errors++;
                        $display("FAIL byte[%0d]: got rs=%0d byte=%02h, want rs=%0d byte=%02h",
                                 byte_idx, rs, wbyte, e[8], e[7:0]);
                    end
                end
                byte_idx++;
            end
            prev_busy = busy;
        end
    end

    // Byte-writer model with configurable latency, one long stall and spurious acks
    int         fixed_lat = 3;
    bit         rand_lat = 1'b0;
    int         lat = 3;
    int         wcnt = 0;
    bit         hold_mode = 1'b0;
    int         hold_left = 0;
    logic [9:0] hold_cap = '0;
    bit         spurious_mode = 1'b0;
    bit         extra = 1'b0;

    always @(posedge clk) begin
        #2;
        if (rst) begin
            ack = 1'b0; wcnt = 0; hold_left = 0; extra = 1'b0;
        end else if (ack) begin
            if (extra) extra = 1'b0;
            else       ack = 1'b0;
        end else if (req) begin
            if (hold_mode && byte_idx == 5) begin
                hold_mode = 1'b0;
                hold_left = 50;
                hold_cap  = {req, rs, wbyte};
            end
            if (hold_left > 0) begin
                check("hold_stable", {22'b0, req, rs, wbyte}, {22'b0, hold_cap});
                hold_left--;
            end else if (wcnt >= lat) begin
                ack   = 1'b1;
                extra = spurious_mode;
                wcnt  = 0;
                lat   = rand_lat ? int'($urandom_range(0, 4)) : fixed_lat;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, want event", name);
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!busy && n < 400) begin @(negedge clk); n++; end
        if (!busy) fail_timeout({name, "_start"});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        wait_start(name);
        while (busy && n < 3000) begin @(negedge clk); n++; end
        if (busy) fail_timeout({name, "_done"});
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (!(byte_idx == k && req) && n < 1000) begin @(negedge clk); n++; end
        if (!(byte_idx == k && req)) fail_timeout("wait_idx");
    endtask

    task automatic summary();
        $display("Result: errors=%0d of %0d checks", errors, checks);
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;

        // First screen after reset: RUNNING / 0xDEADBEEF
        wait_done("first");
        check("first_msg", {29'b0, msg_id}, 0);
        check("first_busy", {31'b0, busy}, 0);

        @(negedge clk); bios = 1'b1; halt = 1'b1;
        wait_done("halt");
        check("halt_msg", {29'b0, msg_id}, 4);

        @(negedge clk); halt = 1'b0; bios = 1'b0;
        wait_done("run");
        check("run_msg", {29'b0, msg_id}, 0);

        // Insert arrives mid-update: old text completes, then an immediate re-send
        @(negedge clk); transf = 1'b1;
        wait_start("transf");
        wait_idx(10);
        insert = 1'b1;
        wait_done("transf");
        check("transf_msg", {29'b0, msg_id}, 1);
        wait_done("insert");
        check("insert_msg", {29'b0, msg_id}, 3);

        // DATA change alone waits for the periodic refresh
        @(negedge clk); data = 32'h0000ABCD;
        wait_done("refresh");
        check("refresh_msg", {29'b0, msg_id}, 3);

        // Long stall on idx 5 plus spurious acks during NEXT
        @(negedge clk); hold_mode = 1'b1; spurious_mode = 1'b1; insert = 1'b0;
        wait_done("hold");
        spurious_mode = 1'b0;
        check("hold_taken", {31'b0, hold_mode}, 0);

        // Reset in the middle of line 2
        @(negedge clk); transf = 1'b0;
        wait_start("pre_reset");
        wait_idx(20);
        @(posedge clk); #3 rst = 1'b1;
        #1;
        check("async_req", {31'b0, req}, 0);
        check("async_busy", {31'b0, busy}, 0);
        @(posedge clk); #3 rst = 1'b0;
        wait_done("post_reset");
        check("post_reset_msg", {29'b0, msg_id}, 0);

        // Randomised flags, data and ack latency
        rand_lat = 1'b1;
        for (int it = 0; it < 25; it++) begin
            logic [3:0] f;
            repeat ($urandom_range(1, 250)) @(negedge clk);
            f = 4'($urandom);
            {halt, insert, bios, transf} = f;
            if ($urandom_range(0, 1) == 1) data = $urandom;
        end
        repeat (700) @(negedge clk);
        begin
            int n = 0;
            while (busy && n < 1000) begin @(negedge clk); n++; end
            if (busy) fail_timeout("final_idle");
        end
        check("final_queue_empty", 32'(exp_q.size()), 0);
        check("final_msg", {29'b0, msg_id}, 32'(model_sel(halt, insert, bios, transf)));
        if (updates_done < 10) begin
            checks++; errors++;
            $display("FAIL update_count: got %0d, want >= 10", updates_done);
        end
        summary();
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got time limit, want completion");
        summary();
        $finish;
    end

endmodule
